text_typewriter: RTL and testbench
==================================

# text_typewriter

Parametrised text source for the on-screen text drawing path. Holds a ROM of several fixed ASCII messages and reveals the selected one character by character, paced by the video frame tick. The glyph renderer reads characters by index and sees unrevealed positions as blank (7'h00). It generalises the single fixed-string lookup used by the title text to multiple messages, a parametrised length and a timed reveal.

## Interface
- `NUM_MSGS`, default 4: number of messages in the ROM.
- `MAX_LEN`, default 16: characters per message slot.
- `CHAR_PERIOD`, default 4: frame ticks per revealed character, ≥1.
- `IDX_W`, default $clog2(MAX_LEN): index width.
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `start` in 1: pulse; latches `msg_sel` and begins the reveal.
- `msg_sel` in $clog2(NUM_MSGS): message to reveal, sampled with `start`.
- `skip` in 1: pulse; completes the reveal immediately.
- `clear` in 1: pulse; blanks the text and returns to idle.
- `rd_idx` in IDX_W: character position requested by the renderer.
- `rd_char` out 7: ASCII at `rd_idx`, or 7'h00 if not revealed or out of range.
- `msg_len` out IDX_W+1: length of the latched message.
- `busy` out 1: reveal in progress.
- `done` out 1: the whole message is revealed.

## Operation
- States are IDLE, TYPE and SHOWN.
- Reset behaviour:
  - State goes to IDLE.
  - `reveal_cnt`, `tick_cnt`, `cur_msg` and `msg_len` go to 0.
  - `rd_char` = 0, `busy` = 0, `done` = 0.
- Message length is the index of the first 7'h00 in the slot, or MAX_LEN if the slot has no 7'h00.
- `start` (any state):
  - Latch `cur_msg` and `msg_len`.
  - `reveal_cnt` = 0, `tick_cnt` = 0.
  - Go to TYPE. A message of length 0 goes straight to SHOWN.
- TYPE: on each `frame_tick`:
  - If `tick_cnt` = CHAR_PERIOD-1: clear `tick_cnt` and increment `reveal_cnt`.
  - Otherwise increment `tick_cnt`.
  - When `reveal_cnt` reaches `msg_len`, go to SHOWN.
- `skip` in TYPE: `reveal_cnt` = `msg_len`, go to SHOWN. `skip` in IDLE or SHOWN is ignored.
- `clear`: `reveal_cnt` = 0, go to IDLE; the latched message is kept.
- Priority when inputs coincide: `Reset` > `clear` > `start` > `skip` > `frame_tick`.
- `rd_char` = ROM[`cur_msg`][`rd_idx`] when `rd_idx` < `reveal_cnt`, otherwise 0.
- `busy` = (state == TYPE). `done` = (state == SHOWN).

## Timing
- `rd_char` is registered with 1-cycle latency: `rd_idx` at edge N gives data after edge N+1.
- `start` sampled at edge N gives `busy` = 1 and the new `msg_len` after edge N.
- The first character appears CHAR_PERIOD `frame_tick`s after `start`.
- `done` rises in the same cycle that the last character becomes visible to `rd_char`, counting the 1-cycle read latency.
- `reveal_cnt` saturates at `msg_len`. `tick_cnt` is held in IDLE and SHOWN.
- `Reset` mid-reveal blanks the text on the next cycle.

## Configuration
- `TEXT_TYPEWRITER_CURSOR_EN` defined:
  - In TYPE, position `reveal_cnt` returns 7'h5F ('_').
  - The cursor toggles visibility every 16 `frame_tick`s, driven by an extra 4-bit counter that resets to 0 and starts visible.
  - No cursor in IDLE or SHOWN.
- Undefined: unrevealed positions always return 0 and the cursor counter is not built.

## Structure
- Package `text_pkg` holds:
  - the message ROM contents as a localparam array.
  - the state enum.
  - the constants CHAR_NULL = 7'h00 and CHAR_CURSOR = 7'h5F.
- Sub-module `text_msg_rom`:
  - combinational lookup of (msg, idx) → 7-bit char.
  - also gives the per-message length as a constant lookup.
- Top-level `text_typewriter` holds the FSM, the counters and the read register.

## Test plan
- ROM msg 0 = "ADVENTURE", CHAR_PERIOD = 4, `start` with `msg_sel` = 0, then 36 `frame_tick`s:
  - `msg_len` = 9.
  - `rd_idx` = 0 returns 7'h41 after the 4th tick and 0 before it.
  - `done` rises after the 36th tick.
- `start`, then 2 chars revealed, then `skip`: next cycle `done` = 1 and `rd_idx` = 8 returns 7'h45.
- `start` msg 1 while TYPE on msg 0: `reveal_cnt` = 0, the new `msg_len` is loaded, and all reads return 0 until the next CHAR_PERIOD ticks.
- `clear` and `start` in the same cycle: IDLE, `busy` = 0, and all reads return 0.
- Full-length message (no 7'h00, length 16):
  - `msg_len` = 16.
  - `rd_idx` = 15 is revealed last.
  - `reveal_cnt` stays at 16 under further `frame_tick`s.
- With `TEXT_TYPEWRITER_CURSOR_EN`: after 1 char revealed, `rd_idx` = 1 returns 7'h5F, then 0 after 16 `frame_tick`s of blink (CHAR_PERIOD = 64).

Source files
------------

// File: rtl/text_pkg.sv
// Shared definitions for the text typewriter: message ROM text, FSM states and
// the special character codes.
package text_pkg;

    localparam int ROM_MSGS  = 4;
    localparam int ROM_LEN   = 16;
    localparam int ROM_SEL_W = $clog2(ROM_MSGS);

    localparam logic [6:0] CHAR_NULL   = 7'h00;
    localparam logic [6:0] CHAR_CURSOR = 7'h5F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TYPE  = 2'd1,
        ST_SHOWN = 2'd2
    } tw_state_e;

    // Each slot is left-justified: character 0 sits in the top byte, short
    // messages are padded with NULs which also terminate them.
    localparam logic [8*ROM_LEN-1:0] MSG_TEXT [ROM_MSGS] = '{
        {"ADVENTURE", 56'h0},
        {"PLAYER ONE", 48'h0},
        "PRESS START NOW!",
        128'h0
    };

    function automatic logic [6:0] rom_char(int msg, int idx);
        logic [8*ROM_LEN-1:0] line;
        rom_char = CHAR_NULL;
        if (msg >= 0 && msg < ROM_MSGS && idx >= 0 && idx < ROM_LEN) begin
            line     = MSG_TEXT[ROM_SEL_W'(msg)] << (8 * idx);
            rom_char = line[8*ROM_LEN-2 -: 7];
        end
    endfunction

endpackage

// File: rtl/text_msg_rom.sv
// Combinational message ROM: character lookup by (message, index) and a
// per-message length table fixed at elaboration.
module text_msg_rom
    import text_pkg::*;
#(
    parameter int NUM_MSGS = 4,
    parameter int MAX_LEN  = 16,
    parameter int IDX_W    = $clog2(MAX_LEN),
    parameter int MSG_W    = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1
) (
    input  logic [MSG_W-1:0] msg_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [6:0]       char_o,
    input  logic [MSG_W-1:0] len_msg_i,
    output logic [IDX_W:0]   len_o
);

    // Length is the position of the first NUL, or the full slot if none.
    function automatic logic [IDX_W:0] slot_len(int m);
        logic [IDX_W:0] n;
        n = (IDX_W+1)'(MAX_LEN);
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            if (rom_char(m, i) == CHAR_NULL) n = (IDX_W+1)'(i);
        end
        return n;
    endfunction

    logic [IDX_W:0] len_tab [NUM_MSGS];

    for (genvar g = 0; g < NUM_MSGS; g++) begin : g_len
        localparam logic [IDX_W:0] SLOT_LEN = slot_len(g);
        assign len_tab[g] = SLOT_LEN;
    end

    always_comb begin
        char_o = CHAR_NULL;
        if (int'(idx_i) < MAX_LEN && int'(msg_i) < NUM_MSGS) begin
            char_o = rom_char(int'(msg_i), int'(idx_i));
        end
    end

    always_comb begin
        len_o = '0;
        if (int'(len_msg_i) < NUM_MSGS) begin
            len_o = len_tab[len_msg_i];
        end
    end

endmodule

// File: rtl/text_typewriter.sv
// Reveals a ROM message one character per CHAR_PERIOD frame ticks.
// Optional blinking cursor at the reveal position: TEXT_TYPEWRITER_CURSOR_EN.
module text_typewriter
    import text_pkg::*;
#(
    parameter int NUM_MSGS    = 4,
    parameter int MAX_LEN     = 16,
    parameter int CHAR_PERIOD = 4,
    parameter int IDX_W       = $clog2(MAX_LEN),
    parameter int MSG_W       = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             start,
    input  logic [MSG_W-1:0] msg_sel,
    input  logic             skip,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [6:0]       rd_char,
    output logic [IDX_W:0]   msg_len,
    output logic             busy,
    output logic             done,
    output tw_state_e        dbg_state
);

    localparam int TICK_W = (CHAR_PERIOD > 1) ? $clog2(CHAR_PERIOD) : 1;

    tw_state_e         state_q, state_d;
    logic [IDX_W:0]    reveal_q, reveal_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [MSG_W-1:0]  cur_msg_q, cur_msg_d;
    logic [IDX_W:0]    len_q, len_d;
    logic [6:0]        rd_char_q, rd_char_d;

    logic [6:0]        rom_char_w;
    logic [IDX_W:0]    sel_len_w;

    text_msg_rom #(
        .NUM_MSGS (NUM_MSGS),
        .MAX_LEN  (MAX_LEN),
        .IDX_W    (IDX_W),
        .MSG_W    (MSG_W)
    ) u_rom (
        .msg_i     (cur_msg_q),
        .idx_i     (rd_idx),
        .char_o    (rom_char_w),
        .len_msg_i (msg_sel),
        .len_o     (sel_len_w)
    );

    always_comb begin
        state_d   = state_q;
        reveal_d  = reveal_q;
        tick_d    = tick_q;
        cur_msg_d = cur_msg_q;
        len_d     = len_q;
        if (clear) begin
            state_d  = ST_IDLE;
            reveal_d = '0;
            tick_d   = '0;
        end else if (start) begin
            cur_msg_d = msg_sel;
            len_d     = sel_len_w;
            reveal_d  = '0;
            tick_d    = '0;
            state_d   = (sel_len_w == '0) ? ST_SHOWN : ST_TYPE;
        end else if (state_q == ST_TYPE) begin
            if (skip) begin
                reveal_d = len_q;
                state_d  = ST_SHOWN;
            end else if (reveal_q == len_q) begin
                // Leave TYPE one cycle after the last reveal so done lines up
                // with the registered read of the final character.
                state_d = ST_SHOWN;
            end else if (frame_tick) begin
                if (tick_q == TICK_W'(CHAR_PERIOD - 1)) begin
                    tick_d   = '0;
                    reveal_d = reveal_q + 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
        end
    end

`ifdef TEXT_TYPEWRITER_CURSOR_EN
    logic [3:0] blink_q;
    logic       cursor_vis_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            blink_q      <= '0;
            cursor_vis_q <= 1'b1;
        end else if (frame_tick) begin
            blink_q <= blink_q + 1'b1;
            if (blink_q == 4'hF) cursor_vis_q <= ~cursor_vis_q;
        end
    end

    always_comb begin
        rd_char_d = ({1'b0, rd_idx} < reveal_q) ? rom_char_w : CHAR_NULL;
        if (state_q == ST_TYPE && {1'b0, rd_idx} == reveal_q && cursor_vis_q) begin
            rd_char_d = CHAR_CURSOR;
        end
    end
`else
    always_comb begin
        rd_char_d = ({1'b0, rd_idx} < reveal_q) ? rom_char_w : CHAR_NULL;
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            reveal_q  <= '0;
            tick_q    <= '0;
            cur_msg_q <= '0;
            len_q     <= '0;
            rd_char_q <= CHAR_NULL;
        end else begin
            state_q   <= state_d;
            reveal_q  <= reveal_d;
            tick_q    <= tick_d;
            cur_msg_q <= cur_msg_d;
            len_q     <= len_d;
            rd_char_q <= rd_char_d;
        end
    end

    assign rd_char   = rd_char_q;
    assign msg_len   = len_q;
    assign busy      = (state_q == ST_TYPE);
    assign done      = (state_q == ST_SHOWN);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_text_typewriter.sv
// Self-checking bench for text_typewriter (default build, CHAR_PERIOD = 4):
// directed literal checks plus a randomized run against a reference model.
module tb_text_typewriter;

    localparam int CP = 4;
    localparam int W  = 14;

    logic       Clk        = 1'b0;
    logic       Reset      = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start      = 1'b0;
    logic [1:0] msg_sel    = '0;
    logic       skip       = 1'b0;
    logic       clear      = 1'b0;
    logic [3:0] rd_idx     = '0;
    logic [6:0] rd_char;
    logic [4:0] msg_len;
    logic       busy;
    logic       done;
    text_pkg::tw_state_e dbg_state;

    text_typewriter dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .start      (start),
        .msg_sel    (msg_sel),
        .skip       (skip),
        .clear      (clear),
        .rd_idx     (rd_idx),
        .rd_char    (rd_char),
        .msg_len    (msg_len),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain strings, elapsed tick count since start.
    string msgs [4] = '{"ADVENTURE", "PLAYER ONE", "PRESS START NOW!", ""};
    int m_state = 0;  // 0 idle, 1 typing, 2 shown
    int m_msg = 0, m_len = 0, m_reveal = 0, m_ticks = 0;
    logic [W-1:0] exp_q [$];

    function automatic logic [6:0] ref_char(int m, int i);
        if (i < msgs[m].len()) return 7'(msgs[m].getc(i));
        return 7'h00;
    endfunction

    always @(posedge Clk) begin : model
        logic [6:0] rd_next;
        rd_next = (int'(rd_idx) < m_reveal) ? ref_char(m_msg, int'(rd_idx)) : 7'h00;
        if (Reset) begin
            m_state = 0; m_msg = 0; m_len = 0; m_reveal = 0; m_ticks = 0;
            rd_next = 7'h00;
        end else if (clear) begin
            m_state = 0; m_reveal = 0;
        end else if (start) begin
            m_msg = int'(msg_sel);
            m_len = msgs[m_msg].len();
            m_ticks = 0; m_reveal = 0;
            m_state = (m_len == 0) ? 2 : 1;
        end else if (m_state == 1) begin
            if (skip) begin
                m_reveal = m_len; m_state = 2;
            end else if (m_reveal == m_len) begin
                m_state = 2;
            end else if (frame_tick) begin
                m_ticks++;
                m_reveal = (m_ticks / CP < m_len) ? m_ticks / CP : m_len;
            end
        end
        exp_q.push_back({m_state == 1, m_state == 2, 5'(m_len), rd_next});
    end

    // Scoreboard compare on the falling edge
    always @(negedge Clk) begin : compare
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            if ({busy, done, msg_len, rd_char} !== e) begin
                errors++;
                $display("FAIL cycle_compare at %0t: got busy=%0b done=%0b len=%0d char=%h, expected busy=%0b done=%0b len=%0d char=%h",
                         $time, busy, done, msg_len, rd_char, e[13], e[12], e[11:7], e[6:0]);
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
        skip       = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
            step();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    initial begin
        Reset = 1'b1;
        repeat (3) step();
        chk("reset_rd_char", rd_char, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_len", msg_len, 0);
        Reset = 1'b0;
        step();

        // Full reveal of ADVENTURE
        rd_idx = 0; msg_sel = 0; start = 1'b1;
        step();
        chk("adv_len", msg_len, 9);
        chk("adv_busy", busy, 1);
        ticks(3);
        chk("adv_before_first", rd_char, 0);
        ticks(1);
        chk("adv_first_char", rd_char, 'h41);
        rd_idx = 8;
        ticks(31);
        chk("adv_last_hidden", rd_char, 0);
        chk("adv_not_done", done, 0);
        ticks(1);
        chk("adv_done", done, 1);
        chk("adv_last_char", rd_char, 'h45);

        // Skip after two characters
        rd_idx = 1; msg_sel = 0; start = 1'b1;
        step();
        ticks(8);
        chk("skip_second_char", rd_char, 'h44);
        skip = 1'b1; rd_idx = 8;
        step();
        chk("skip_done", done, 1);
        chk("skip_busy", busy, 0);
        step();
        chk("skip_last_char", rd_char, 'h45);

        // Restart onto another message mid-reveal
        msg_sel = 0; start = 1'b1; rd_idx = 0;
        step();
        ticks(5);
        msg_sel = 1; start = 1'b1;
        step();
        chk("restart_len", msg_len, 10);
        chk("restart_busy", busy, 1);
        step();
        chk("restart_blank", rd_char, 0);
        ticks(3);
        chk("restart_still_blank", rd_char, 0);
        ticks(1);
        chk("restart_first", rd_char, 'h50);

        // clear beats start
        clear = 1'b1; start = 1'b1; msg_sel = 2;
        step();
        chk("clear_busy", busy, 0);
        chk("clear_done", done, 0);
        chk("clear_len_kept", msg_len, 10);
        step();
        chk("clear_blank", rd_char, 0);
        ticks(4);
        chk("clear_idle_blank", rd_char, 0);

        // Full-length message
        msg_sel = 2; start = 1'b1; rd_idx = 15;
        step();
        chk("full_len", msg_len, 16);
        ticks(63);
        chk("full_last_hidden", rd_char, 0);
        chk("full_not_done", done, 0);
        ticks(1);
        chk("full_last_char", rd_char, 'h21);
        chk("full_done", done, 1);
        ticks(8);
        chk("full_saturated", rd_char, 'h21);

        // Empty message goes straight to shown; skip there is ignored
        msg_sel = 3; start = 1'b1;
        step();
        chk("empty_done", done, 1);
        chk("empty_busy", busy, 0);
        chk("empty_len", msg_len, 0);
        skip = 1'b1;
        step();
        chk("empty_skip_done", done, 1);

        // Reset mid-reveal
        msg_sel = 0; start = 1'b1; rd_idx = 0;
        step();
        ticks(8);
        Reset = 1'b1;
        step();
        chk("midreset_blank", rd_char, 0);
        chk("midreset_len", msg_len, 0);
        Reset = 1'b0;

        // Randomized run
        repeat (4000) begin
            Reset      = ($urandom_range(0, 199) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            start      = ($urandom_range(0, 39) == 0);
            skip       = ($urandom_range(0, 59) == 0);
            clear      = ($urandom_range(0, 79) == 0);
            msg_sel    = 2'($urandom_range(0, 3));
            rd_idx     = 4'($urandom_range(0, 15));
            step();
        end
        Reset = 1'b0;
        repeat (3) step();
        @(negedge Clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
